// File: rtl/if_fetch_unit.sv
// if_fetch_unit
// Instruction-fetch front end and writer side of the IF/ID pipeline register.
// Owns the PC, fetches over a variable-latency req/ready handshake and holds
// one fetched instruction in a single-entry buffer until the IF/ID register
// takes it.
//
// Ports
//   clk            rising-edge clock
//   reset          asynchronous active-low reset
//   pc_write       hazard unit: 0 = IF/ID stalled, buffer holds
//   branch_taken   EX redirect pulse
//   branch_target  redirect PC, valid with branch_taken
//   imem_req       instruction memory request
//   imem_addr      request address, held until imem_ready
//   imem_ready     response valid (ignored when imem_req=0)
//   imem_rdata     instruction returned with imem_ready
//   PC_Out         buffered instruction PC
//   Instruction    buffered instruction
//   IF_ID_Write    IF/ID load enable
//   flush_IFID     IF/ID clear
module if_fetch_unit #(
    parameter logic [63:0] RESET_PC = 64'h0,
    parameter int unsigned PC_INCR  = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pc_write,
    input  logic        branch_taken,
    input  logic [63:0] branch_target,
    output logic        imem_req,
    output logic [63:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [63:0] PC_Out,
    output logic [31:0] Instruction,
    output logic        IF_ID_Write,
    output logic        flush_IFID
);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        STALL = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t      state_q,      state_d;
    logic [63:0] pc_q,         pc_d;
    logic [63:0] fb_pc_q,      fb_pc_d;
    logic [31:0] fb_instr_q,   fb_instr_d;
    logic        fb_valid_q,   fb_valid_d;
    logic [63:0] drain_addr_q, drain_addr_d;

    logic consume;
    logic req_raw;

    // The buffer is handed to IF/ID only when it holds something, the
    // hazard unit lets it through and no redirect is squashing it.
    assign consume = fb_valid_q & pc_write & ~branch_taken;

    // STALL only requests when the buffer is emptied on the same edge, so a
    // response can never arrive into a full buffer.
    always_comb begin
        req_raw = 1'b0;
        case (state_q)
            FETCH:   req_raw = 1'b1;
            DRAIN:   req_raw = 1'b1;
            STALL:   req_raw = consume;
            default: req_raw = 1'b0;
        endcase
    end

    assign imem_req    = reset & req_raw;
    assign imem_addr   = (state_q == DRAIN) ? drain_addr_q : pc_q;
    assign PC_Out      = fb_pc_q;
    assign Instruction = fb_instr_q;
    assign IF_ID_Write = reset & consume;
    assign flush_IFID  = reset & branch_taken;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        fb_pc_d      = fb_pc_q;
        fb_instr_d   = fb_instr_q;
        fb_valid_d   = fb_valid_q;
        drain_addr_d = drain_addr_q;

        if (branch_taken) begin
            // Redirect wins over everything: any response on this edge is dropped.
            pc_d       = branch_target;
            fb_valid_d = 1'b0;
            case (state_q)
                FETCH: begin
                    // A request still in flight must be completed at its old
                    // address before the target can be requested.
                    if (!imem_ready) begin
                        drain_addr_d = pc_q;
                        state_d      = DRAIN;
                    end else begin
                        state_d = FETCH;
                    end
                end
                STALL:   state_d = FETCH;
                // The drained request finishing on this edge ends the drain;
                // otherwise keep draining with the newer target queued in pc.
                DRAIN:   state_d = imem_ready ? FETCH : DRAIN;
                default: state_d = FETCH;
            endcase
        end else begin
            case (state_q)
                FETCH: begin
                    if (imem_ready) begin
                        fb_pc_d    = pc_q;
                        fb_instr_d = imem_rdata;
                        fb_valid_d = 1'b1;
                        pc_d       = pc_q + 64'(PC_INCR);
                        state_d    = STALL;
                    end
                end
                STALL: begin
                    if (consume) begin
                        if (imem_ready) begin
                            fb_pc_d    = pc_q;
                            fb_instr_d = imem_rdata;
                            fb_valid_d = 1'b1;
                            pc_d       = pc_q + 64'(PC_INCR);
                        end else begin
                            // Request stays open; FETCH keeps req/addr stable.
                            fb_valid_d = 1'b0;
                            state_d    = FETCH;
                        end
                    end
                end
                DRAIN: begin
                    if (imem_ready) begin
                        state_d = FETCH;
                    end
                end
                default: state_d = FETCH;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= FETCH;
            pc_q         <= RESET_PC;
            fb_pc_q      <= 64'h0;
            fb_instr_q   <= 32'h0;
            fb_valid_q   <= 1'b0;
            drain_addr_q <= 64'h0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            fb_pc_q      <= fb_pc_d;
            fb_instr_q   <= fb_instr_d;
            fb_valid_q   <= fb_valid_d;
            drain_addr_q <= drain_addr_d;
        end
    end

endmodule
